// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-master (CPU, Ethernet RX DMA) arbiter for a single-port data memory.
// Ports: clk/rst (async active-high); cpu_req/we/addr/wdata -> cpu_ack/rdata/stall;
//   dma_req/we/last/addr/wdata -> dma_ack/rdata; mem_cs/we/addr/wdata -> shared memory, mem_rdata <- memory.
// Optional feature: define ARB_STARVE_EN to let a starving DMA win IDLE arbitration over the CPU.
module mem_bus_arb #(
    parameter int DW = 32,
    parameter int BURST_MAX = 8,
    parameter int STARVE_LIM = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_last,
    input  logic [DW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, C_ISS, C_ACK, D_ISS, D_ACK} state_t;
    state_t        state;
    logic [7:0]    burst_cnt;
    logic          last_q;
    logic [DW-1:0] cpu_rd_q, dma_rd_q;
    logic          starve, grant_dma, cont;
`ifdef ARB_STARVE_EN
    logic [7:0] wait_cnt;
    assign starve = wait_cnt == 8'(STARVE_LIM);
    // Counts cycles the DMA is kept waiting; cleared when it is granted from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == IDLE && grant_dma)
            wait_cnt <= '0;
        else if (dma_req && state != D_ISS && state != D_ACK && !starve)
            wait_cnt <= wait_cnt + 8'd1;
    end
`else
    assign starve = 1'b0;
`endif
    assign grant_dma = dma_req & (starve | ~cpu_req);
    // Continue the burst only if the word just issued was not the last and the count after this ack is below the cap.
    assign cont = dma_req & ~last_q & (({1'b0, burst_cnt} + 9'd1) < 9'(BURST_MAX));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last_q    <= 1'b0;
            cpu_rd_q  <= '0;
            dma_rd_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    state     <= grant_dma ? D_ISS : (cpu_req ? C_ISS : IDLE);
                end
                C_ISS: state <= C_ACK;
                C_ACK: begin
                    cpu_rd_q <= mem_rdata;
                    state    <= IDLE;
                end
                D_ISS: begin
                    last_q <= dma_last;
                    state  <= D_ACK;
                end
                D_ACK: begin
                    dma_rd_q  <= mem_rdata;
                    burst_cnt <= burst_cnt + 8'd1;
                    state     <= cont ? D_ISS : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign cpu_ack   = state == C_ACK;
    assign dma_ack   = state == D_ACK;
    assign cpu_rdata = cpu_ack ? mem_rdata : cpu_rd_q;
    assign dma_rdata = dma_ack ? mem_rdata : dma_rd_q;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign mem_cs    = state == C_ISS || state == D_ISS;
    assign mem_we    = state == C_ISS ? cpu_we : (state == D_ISS ? dma_we : 1'b0);
    assign mem_addr  = state == D_ISS ? dma_addr : cpu_addr;
    assign mem_wdata = state == D_ISS ? dma_wdata : cpu_wdata;
endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed self-checking bench for mem_bus_arb (BURST_MAX=8, STARVE_LIM=4).
module tb_mem_bus_arb;
    localparam logic [31:0] KEY = 32'h5A5A_0000;
    logic clk = 1'b0, rst = 1'b0;
    logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, dma_last = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
    logic cpu_ack, cpu_stall, dma_ack, mem_cs, mem_we;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [31:0] mem [logic [31:0]];
    int cyc = 0, n_cmp = 0, n_err = 0;

    mem_bus_arb #(.DW(32), .BURST_MAX(8), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Memory model: one-cycle read latency; unwritten words read as addr ^ KEY.
    always @(posedge clk)
        if (mem_cs) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : (mem_addr ^ KEY);
        end

    task automatic do_reset();
        rst = 1; cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0; dma_last = 0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; cpu_req = 1; dma_req = 1;
        #1;
        n_cmp++; if (mem_cs !== 1'b0) begin n_err++; $display("FAIL rst_cs: got %0h want 0", mem_cs); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0h want 0", mem_we); end
        n_cmp++; if ({cpu_ack, dma_ack} !== 2'b00) begin n_err++; $display("FAIL rst_acks: got %0b want 00", {cpu_ack, dma_ack}); end
        n_cmp++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %0h/%0h want 0/0", cpu_rdata, dma_rdata); end
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %0h want 1", cpu_stall); end
        do_reset();
    endtask

    task automatic test_cpu_read();
        do_reset();
        mem[32'h1001_0000] = 32'hDEAD_BEEF;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1001_0000;
        @(negedge clk);
        n_cmp++; if (mem_cs !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL cpu_iss: got cs=%0h we=%0h want 1/0", mem_cs, mem_we); end
        n_cmp++; if (mem_addr !== 32'h1001_0000) begin n_err++; $display("FAIL cpu_iss_addr: got %0h want 10010000", mem_addr); end
        n_cmp++; if (cpu_ack !== 1'b0 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL cpu_iss_ack: got ack=%0h stall=%0h want 0/1", cpu_ack, cpu_stall); end
        @(negedge clk);
        n_cmp++; if (cpu_ack !== 1'b1 || dma_ack !== 1'b0) begin n_err++; $display("FAIL cpu_ack: got %0h/%0h want 1/0", cpu_ack, dma_ack); end
        n_cmp++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cpu_rdata: got %0h want deadbeef", cpu_rdata); end
        n_cmp++; if (mem_cs !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpu_ack_cs: got cs=%0h stall=%0h want 0/0", mem_cs, cpu_stall); end
        cpu_req = 0;
    endtask

    task automatic test_hold();
        dma_req = 1; dma_we = 0; dma_last = 1; dma_addr = 32'h20;
        @(negedge clk);
        n_cmp++; if (cpu_ack !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL hold_idle: got ack=%0h rdata=%0h want 0/deadbeef", cpu_ack, cpu_rdata); end
        @(negedge clk);
        n_cmp++; if (mem_cs !== 1'b1 || mem_addr !== 32'h20) begin n_err++; $display("FAIL hold_dma_iss: got cs=%0h addr=%0h want 1/20", mem_cs, mem_addr); end
        @(negedge clk);
        n_cmp++; if (dma_ack !== 1'b1 || dma_rdata !== (32'h20 ^ KEY)) begin n_err++; $display("FAIL hold_dma_ack: got ack=%0h rdata=%0h want 1/%0h", dma_ack, dma_rdata, 32'h20 ^ KEY); end
        n_cmp++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL hold_cpu_rdata: got %0h want deadbeef", cpu_rdata); end
        dma_req = 0;
        @(negedge clk);
        n_cmp++; if (dma_ack !== 1'b0 || dma_rdata !== (32'h20 ^ KEY)) begin n_err++; $display("FAIL hold_dma_rdata: got ack=%0h rdata=%0h want 0/%0h", dma_ack, dma_rdata, 32'h20 ^ KEY); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'h1111;
        dma_req = 1; dma_we = 1; dma_addr = 32'h200; dma_wdata = 32'h2222; dma_last = 1;
        @(negedge clk);
        n_cmp++; if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h1111) begin n_err++; $display("FAIL same_cpu_iss: got cs=%0h we=%0h addr=%0h wd=%0h want 1/1/100/1111", mem_cs, mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        n_cmp++; if (cpu_ack !== 1'b1 || dma_ack !== 1'b0) begin n_err++; $display("FAIL same_cpu_ack: got %0h/%0h want 1/0", cpu_ack, dma_ack); end
        cpu_req = 0;
        @(negedge clk);
        n_cmp++; if (mem_cs !== 1'b0) begin n_err++; $display("FAIL same_idle: got cs=%0h want 0", mem_cs); end
        @(negedge clk);
        n_cmp++; if (mem_cs !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h2222) begin n_err++; $display("FAIL same_dma_iss: got cs=%0h addr=%0h wd=%0h want 1/200/2222", mem_cs, mem_addr, mem_wdata); end
        @(negedge clk);
        n_cmp++; if (dma_ack !== 1'b1 || cpu_ack !== 1'b0) begin n_err++; $display("FAIL same_dma_ack: got %0h/%0h want 1/0", dma_ack, cpu_ack); end
        dma_req = 0;
    endtask

    task automatic test_burst_split();
        int k = 0, bad_addr = 0, got = 0;
        int ack_cyc [12];
        do_reset();
        dma_req = 1; dma_we = 1; dma_last = 0; dma_addr = 32'h400; dma_wdata = 32'hD000;
        for (int i = 0; i < 60 && k < 12; i++) begin
            @(negedge clk);
            if (mem_cs && mem_addr !== 32'h400 + 32'(4 * k)) bad_addr++;
            if (dma_ack) begin
                ack_cyc[k] = cyc; k++;
                dma_addr = 32'h400 + 32'(4 * k); dma_wdata = 32'hD000 + 32'(k);
                if (k == 12) dma_req = 0;
            end
        end
        n_cmp++; if (k !== 12) begin n_err++; $display("FAIL burst_count: got %0d want 12", k); end
        n_cmp++; if (bad_addr !== 0) begin n_err++; $display("FAIL burst_addr: got %0d bad want 0", bad_addr); end
        if (k == 12) begin
            n_cmp++; if (ack_cyc[7] - ack_cyc[0] !== 14) begin n_err++; $display("FAIL burst_first8: got %0d want 14", ack_cyc[7] - ack_cyc[0]); end
            n_cmp++; if (ack_cyc[8] - ack_cyc[7] !== 3) begin n_err++; $display("FAIL burst_rearb_gap: got %0d want 3", ack_cyc[8] - ack_cyc[7]); end
            n_cmp++; if (ack_cyc[11] - ack_cyc[8] !== 6) begin n_err++; $display("FAIL burst_last4: got %0d want 6", ack_cyc[11] - ack_cyc[8]); end
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h42C;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                got = 1;
                n_cmp++; if (cpu_rdata !== 32'hD00B) begin n_err++; $display("FAIL burst_readback: got %0h want d00b", cpu_rdata); end
            end
        end
        cpu_req = 0;
        n_cmp++; if (got !== 1) begin n_err++; $display("FAIL burst_readback_ack: got %0d want 1", got); end
    endtask

    task automatic test_last_and_cpu();
        int k = 0, overlap = 0, cpu_cyc = 0, last_dack = 0, dacks_at_cpu = -1;
        do_reset();
        dma_req = 1; dma_we = 0; dma_last = 0; dma_addr = 32'h800;
        for (int i = 0; i < 40 && cpu_cyc == 0; i++) begin
            @(negedge clk);
            if (cpu_ack && dma_ack) overlap++;
            if (dma_ack) begin
                k++; last_dack = cyc;
                if (k == 1) begin cpu_req = 1; cpu_we = 0; cpu_addr = 32'h900; end
                dma_addr = 32'h800 + 32'(4 * k); dma_last = (k == 2);
            end
            if (cpu_ack) begin
                cpu_cyc = cyc; dacks_at_cpu = k;
                n_cmp++; if (cpu_rdata !== (32'h900 ^ KEY)) begin n_err++; $display("FAIL last_cpu_rdata: got %0h want %0h", cpu_rdata, 32'h900 ^ KEY); end
                cpu_req = 0; dma_req = 0;
            end
        end
        n_cmp++; if (dacks_at_cpu !== 3) begin n_err++; $display("FAIL last_dma_acks: got %0d want 3", dacks_at_cpu); end
        n_cmp++; if (cpu_cyc - last_dack !== 3) begin n_err++; $display("FAIL last_cpu_gap: got %0d want 3", cpu_cyc - last_dack); end
        n_cmp++; if (overlap !== 0) begin n_err++; $display("FAIL last_overlap: got %0d want 0", overlap); end
        n_cmp++; if (dma_rdata !== (32'h808 ^ KEY)) begin n_err++; $display("FAIL last_dma_rdata: got %0h want %0h", dma_rdata, 32'h808 ^ KEY); end
    endtask

    task automatic test_starve();
        int cpu_acks = 0, got = 0;
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hA00;
        dma_req = 1; dma_we = 0; dma_last = 1; dma_addr = 32'hB00;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack) cpu_acks++;
            if (dma_ack) begin got = 1; cpu_req = 0; dma_req = 0; end
        end
`ifdef ARB_STARVE_EN
        n_cmp++; if (got !== 1) begin n_err++; $display("FAIL starve_grant: got %0d want 1", got); end
        n_cmp++; if (cpu_acks !== 2) begin n_err++; $display("FAIL starve_cpu_first: got %0d want 2", cpu_acks); end
`else
        n_cmp++; if (got !== 0) begin n_err++; $display("FAIL strict_no_dma: got %0d want 0", got); end
        n_cmp++; if (cpu_acks !== 13) begin n_err++; $display("FAIL strict_cpu_acks: got %0d want 13", cpu_acks); end
`endif
        cpu_req = 0; dma_req = 0;
    endtask

    task automatic test_reset_mid_dma();
        int acks = 0, cs = 0;
        do_reset();
        dma_req = 1; dma_we = 0; dma_last = 0; dma_addr = 32'hC00;
        @(negedge clk);
        n_cmp++; if (mem_cs !== 1'b1) begin n_err++; $display("FAIL rmid_iss: got cs=%0h want 1", mem_cs); end
        rst = 1;
        #1;
        n_cmp++; if (mem_cs !== 1'b0 || dma_ack !== 1'b0) begin n_err++; $display("FAIL rmid_async: got cs=%0h ack=%0h want 0/0", mem_cs, dma_ack); end
        dma_req = 0;
        @(negedge clk);
        rst = 0;
        repeat (6) begin
            @(negedge clk);
            if (dma_ack) acks++;
            if (mem_cs) cs++;
        end
        n_cmp++; if (acks !== 0 || cs !== 0) begin n_err++; $display("FAIL rmid_after: got acks=%0d cs=%0d want 0/0", acks, cs); end
        n_cmp++; if (dma_rdata !== 32'h0) begin n_err++; $display("FAIL rmid_rdata: got %0h want 0", dma_rdata); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_cpu_read();
        test_hold();
        test_same_cycle();
        test_burst_split();
        test_last_and_cpu();
        test_starve();
        test_reset_mid_dma();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
